// File: rtl/rv32_register_file_mp.sv
// rv32_register_file_mp
//
// Multi-port integer register file for the rv32 core. Read ports sit on the
// decode side, write ports on the writeback side. After reset, or when
// `clear` is asserted while the file is usable, a sweep zeroes entries
// 1..NUM_REGS-1 one per clock. `ready` is low for the whole sweep so the
// pipeline stalls until the file holds known contents again.
//
// Optional feature macro: RV32_REGFILE_BYPASS_EN
//   When defined, write data is forwarded combinationally to any read port
//   that addresses the same register in the same cycle. Forwarding only
//   happens while the file is ready and no clear is requested. When the
//   macro is undefined, reads return stored contents only. Storage
//   behaviour is the same in both builds.
//
// Register 0 is hardwired to zero. Its storage slot exists but is never
// written and never observed.
//
// state   | meaning
// --------+------------------------------------------------------------
// CLEAR   | sweep in progress; ptr is the entry zeroed on the next edge
// READY   | file usable; writes accepted, reads return contents

module rv32_register_file_mp #(
    parameter int NUM_READ   = 3,
    parameter int NUM_WRITE  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  clear,
    output logic                                  ready,
    input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]   rs,
    output logic [NUM_READ-1:0][DATA_WIDTH-1:0]   o,
    input  logic [NUM_WRITE-1:0]                  we,
    input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0]  rw,
    input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0]  d
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [DATA_WIDTH-1:0]   mem [NUM_REGS];

    // Sequencing: the sweep walks ptr from 1 to NUM_REGS-1 and then hands the file back
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_CLEAR;
            ptr   <= FIRST_ADDR;
            ready <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (ptr == LAST_ADDR) begin
                        state <= ST_READY;
                        ready <= 1'b1;
                    end else begin
                        ptr <= ptr + ADDR_WIDTH'(1);
                    end
                end
                ST_READY: begin
                    if (clear) begin
                        state <= ST_CLEAR;
                        ptr   <= FIRST_ADDR;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                    ptr   <= FIRST_ADDR;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage update: sweep zeroing, or port writes where the later port overrides earlier ones
    always_ff @(posedge clk) begin
        if (resetn) begin
            if (state == ST_CLEAR) begin
                mem[ptr] <= '0;
            end else if (!clear) begin
                for (int j = 0; j < NUM_WRITE; j++) begin
                    if (we[j] && (rw[j] != '0)) begin
                        mem[rw[j]] <= d[j];
                    end
                end
            end
        end
    end

    // Read ports: zero while not ready or for x0, otherwise stored (or forwarded) data
    always_comb begin
        for (int i = 0; i < NUM_READ; i++) begin
            o[i] = '0;
            if (ready && (rs[i] != '0)) begin
                o[i] = mem[rs[i]];
`ifdef RV32_REGFILE_BYPASS_EN
                if (!clear) begin
                    for (int j = 0; j < NUM_WRITE; j++) begin
                        if (we[j] && (rw[j] == rs[i])) begin
                            o[i] = d[j];
                        end
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_rv32_register_file_mp.sv
// Bench for rv32_register_file_mp: default configuration (3R/2W, 32x32) and a
// reduced one (4R/1W, 16x64). Stimulus pushes expected outputs into a queue;
// a negedge monitor pops and compares them against the live outputs.

module tb_rv32_register_file_mp;

`ifdef RV32_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: defaults
    logic             resetn_a, clear_a, ready_a;
    logic [2:0][4:0]  rs_a;
    logic [2:0][31:0] o_a;
    logic [1:0]       we_a;
    logic [1:0][4:0]  rw_a;
    logic [1:0][31:0] d_a;

    // instance B: 4 read, 1 write, 64-bit, 16 entries
    logic             resetn_b, clear_b, ready_b;
    logic [3:0][3:0]  rs_b;
    logic [3:0][63:0] o_b;
    logic [0:0]       we_b;
    logic [0:0][3:0]  rw_b;
    logic [0:0][63:0] d_b;

    rv32_register_file_mp dut_a (
        .clk    (clk),
        .resetn (resetn_a),
        .clear  (clear_a),
        .ready  (ready_a),
        .rs     (rs_a),
        .o      (o_a),
        .we     (we_a),
        .rw     (rw_a),
        .d      (d_a)
    );

    rv32_register_file_mp #(
        .NUM_READ   (4),
        .NUM_WRITE  (1),
        .DATA_WIDTH (64),
        .NUM_REGS   (16)
    ) dut_b (
        .clk    (clk),
        .resetn (resetn_b),
        .clear  (clear_b),
        .ready  (ready_b),
        .rs     (rs_b),
        .o      (o_b),
        .we     (we_b),
        .rw     (rw_b),
        .d      (d_b)
    );

    typedef struct {
        int          sel;   // 0: o_a, 1: ready_a, 2: o_b, 3: ready_b
        int          port;
        logic [63:0] exp;
        string       name;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    errors = 0;

    item_t       cur;
    logic [63:0] act;

    // monitor: compare every queued expectation against the outputs at the negedge
    always @(negedge clk) begin
        while (q.size() > 0) begin
            cur = q.pop_front();
            case (cur.sel)
                0:       act = {32'b0, o_a[cur.port]};
                1:       act = {63'b0, ready_a};
                2:       act = o_b[cur.port];
                default: act = {63'b0, ready_b};
            endcase
            checks++;
            if (act !== cur.exp) begin
                errors++;
                $display("FAIL %s port=%0d actual=%h required=%h", cur.name, cur.port, act, cur.exp);
            end
        end
    end

    task automatic push(input int sel, input int port, input logic [63:0] exp, input string name);
        item_t it;
        it.sel  = sel;
        it.port = port;
        it.exp  = exp;
        it.name = name;
        q.push_back(it);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // edges first..last of a sweep on A; ready expected only after edge 31
    task automatic sweep_a(input int first, input int last, input int clr_at);
        for (int k = first; k <= last; k++) begin
            clear_a = (k == clr_at);
            step();
            push(1, 0, {63'b0, (k == 31)}, "sweep_ready_a");
        end
        clear_a = 1'b0;
    endtask

    task automatic sweep_b(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            step();
            push(3, 0, {63'b0, (k == 15)}, "sweep_ready_b");
        end
    endtask

    logic [31:0] pre5;

    initial begin
        resetn_a = 1'b0; clear_a = 1'b0; rs_a = '0; we_a = '0; rw_a = '0; d_a = '0;
        resetn_b = 1'b0; clear_b = 1'b0; rs_b = '0; we_b = '0; rw_b = '0; d_b = '0;
        pre5 = '0;

        // ---------------- instance A ----------------
        step(); step();
        rs_a[0] = 5'd5;
        push(1, 0, 64'd0, "rst_ready_a");
        push(0, 0, 64'd0, "rst_o_a");
        resetn_a = 1'b1;
        sweep_a(1, 31, 0);

        // preload storage with random data
        we_a[0] = 1'b1;
        for (int a = 1; a < 32; a++) begin
            rw_a[0] = 5'(a);
            d_a[0]  = $urandom;
            if (a == 5) pre5 = d_a[0];
            step();
        end
        we_a = '0;
        rs_a[2] = 5'd5;
        push(0, 2, {32'b0, pre5}, "preload_rd5");
        step();

        // reset held 2 cycles, then full sweep and all-zero readback
        resetn_a = 1'b0;
        step(); step();
        push(1, 0, 64'd0, "rst2_ready_a");
        resetn_a = 1'b1;
        sweep_a(1, 31, 0);
        for (int a = 0; a < 32; a++) begin
            for (int i = 0; i < 3; i++) begin
                rs_a[i] = 5'(a);
                push(0, i, 64'd0, "swept_zero");
            end
            step();
        end

        // basic write and read
        we_a[0] = 1'b1; rw_a[0] = 5'd5; d_a[0] = 32'hDEADBEEF;
        rs_a[1] = 5'd5;
        push(0, 1, BYP ? 64'hDEADBEEF : 64'd0, "wr_same_cycle");
        step();
        we_a = '0;
        push(0, 1, 64'hDEADBEEF, "wr_next_cycle");
        step();

        // port conflict: higher port wins
        we_a = 2'b11; rw_a[0] = 5'd7; rw_a[1] = 5'd7; d_a[0] = 32'h11; d_a[1] = 32'h22;
        rs_a[0] = 5'd7;
        push(0, 0, BYP ? 64'h22 : 64'd0, "conflict_same_cycle");
        step();
        we_a = 2'b01; rw_a[0] = 5'd0; d_a[0] = 32'hFF;
        rs_a[2] = 5'd0;
        push(0, 0, 64'h22, "conflict_rd7");
        push(0, 2, 64'd0, "x0_same_cycle");
        step();
        we_a = '0;
        push(0, 2, 64'd0, "x0_after_write");
        push(0, 0, 64'h22, "conflict_rd7_hold");
        step();

        // clear priority over a simultaneous write; writes in sweep are dropped
        clear_a = 1'b1;
        we_a[0] = 1'b1; rw_a[0] = 5'd3; d_a[0] = 32'h55;
        rs_a[0] = 5'd3;
        push(1, 0, 64'd1, "clr_ready_before");
        push(0, 0, 64'd0, "clr_no_forward");
        step();
        clear_a = 1'b0;
        rs_a[1] = 5'd5;
        push(1, 0, 64'd0, "clr_ready_fell");
        push(0, 1, 64'd0, "clr_forced_zero");
        sweep_a(1, 31, 10);
        we_a = '0;
        push(0, 0, 64'd0, "clr_rd3");
        push(0, 1, 64'd0, "clr_rd5");
        rs_a[2] = 5'd7;
        push(0, 2, 64'd0, "clr_rd7");
        step();

        // reset at sweep edge 10 restarts the full sweep
        clear_a = 1'b1;
        step();
        clear_a = 1'b0;
        sweep_a(1, 9, 0);
        resetn_a = 1'b0;
        step();
        push(1, 0, 64'd0, "midrst_ready");
        resetn_a = 1'b1;
        sweep_a(1, 31, 0);

        // ---------------- instance B ----------------
        step();
        push(3, 0, 64'd0, "rst_ready_b");
        resetn_b = 1'b1;
        sweep_b(1, 15);

        we_b[0] = 1'b1; rw_b[0] = 4'd5; d_b[0] = 64'hDEADBEEF_CAFEF00D;
        rs_b[1] = 4'd5;
        push(2, 1, BYP ? 64'hDEADBEEF_CAFEF00D : 64'd0, "b_wr_same_cycle");
        step();
        rw_b[0] = 4'd7; d_b[0] = 64'h11;
        push(2, 1, 64'hDEADBEEF_CAFEF00D, "b_wr_next_cycle");
        step();
        rw_b[0] = 4'd7; d_b[0] = 64'h22;
        step();
        rw_b[0] = 4'd0; d_b[0] = 64'hFF;
        rs_b[0] = 4'd7; rs_b[3] = 4'd0;
        step();
        we_b = '0;
        push(2, 0, 64'h22, "b_rd7");
        push(2, 3, 64'd0, "b_x0");
        push(2, 1, 64'hDEADBEEF_CAFEF00D, "b_rd5_hold");
        step();

        step();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
